// File: rtl/key_schedule_gen.sv
// Iterative AES key expansion for AES-128/192/256. Streams w[0..4*(NK+7)-1] one word
// per valid/ready handshake; rcon is produced by GF(2^8) doubling rather than a table.

module key_schedule_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Forward AES S-box, entry 0 in the top byte.
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = TBL[{~a, 3'b000} +: 8];
endmodule

module key_schedule_gen #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                word_valid,
  input  logic                word_ready,
  output logic [31:0]         word_out,
  output logic [5:0]          word_index,
  output logic [7:0]          rcon_out,
  output logic                done
);
  localparam int unsigned NK          = KEY_BITS / 32;
  localparam int unsigned TOTAL_WORDS = 4 * (NK + 7);

  generate
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("key_schedule_gen: KEY_BITS must be 128, 192 or 256");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t               state_q, state_d;
  logic [NK-1:0][31:0]  win_q, win_d;
  logic [2:0]           pos_q, pos_d;
  logic [7:0]           rcon_q, rcon_d;
  logic [31:0]          word_d;
  logic [5:0]           index_d;
  logic [7:0]           rcon_out_d;
  logic                 valid_d, busy_d, done_d;

  logic [5:0]           nidx;
  logic [2:0]           npos;
  logic [31:0]          last_w, rot_w, sb_in, sb_out, temp_w, next_w;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  // Window holds w[i-NK+1..i] once the key words are exhausted; win_q[0] is the oldest.
  assign nidx   = word_index + 6'd1;
  assign npos   = (pos_q == 3'(NK - 1)) ? 3'd0 : pos_q + 3'd1;
  assign last_w = win_q[NK-1];
  assign rot_w  = {last_w[23:0], last_w[31:24]};
  assign sb_in  = (npos == 3'd0) ? rot_w : last_w;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    key_schedule_sbox u_sbox (
      .a (sb_in[8*b +: 8]),
      .y (sb_out[8*b +: 8])
    );
  end

  // Temp word selection for the next index.
  always_comb begin
    if (npos == 3'd0) begin
      temp_w = sb_out ^ {rcon_q, 24'h000000};
    end else if (NK == 8 && npos == 3'd4) begin
      temp_w = sb_out;
    end else begin
      temp_w = last_w;
    end
  end

  assign next_w = win_q[0] ^ temp_w;

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    pos_d      = pos_q;
    rcon_d     = rcon_q;
    word_d     = word_out;
    index_d    = word_index;
    rcon_out_d = rcon_out;
    valid_d    = word_valid;
    busy_d     = busy;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          for (int unsigned k = 0; k < NK; k++) begin
            win_d[k] = key_in[KEY_BITS-1-32*k -: 32];
          end
          word_d     = key_in[KEY_BITS-1 -: 32];
          index_d    = 6'd0;
          pos_d      = 3'd0;
          rcon_out_d = 8'h00;
          rcon_d     = 8'h01;
          valid_d    = 1'b1;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (word_ready) begin
          if (word_index == 6'(TOTAL_WORDS - 1)) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
          end else begin
            index_d    = nidx;
            pos_d      = npos;
            rcon_out_d = 8'h00;
            if (nidx < 6'(NK)) begin
              for (int unsigned k = 0; k < NK; k++) begin
                if (nidx == 6'(k)) word_d = win_q[k];
              end
            end else begin
              word_d = next_w;
              for (int unsigned k = 0; k < NK - 1; k++) begin
                win_d[k] = win_q[k+1];
              end
              win_d[NK-1] = next_w;
              if (npos == 3'd0) begin
                rcon_out_d = rcon_q;
                rcon_d     = xtime(rcon_q);
              end
            end
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      win_q      <= '0;
      pos_q      <= 3'd0;
      rcon_q     <= 8'h01;
      word_out   <= 32'h0;
      word_index <= 6'd0;
      rcon_out   <= 8'h00;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      pos_q      <= pos_d;
      rcon_q     <= rcon_d;
      word_out   <= word_d;
      word_index <= index_d;
      rcon_out   <= rcon_out_d;
      word_valid <= valid_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end
endmodule

// File: tb/tb_key_schedule_gen.sv
// Self-checking bench for key_schedule_gen: FIPS-197 vector table plus an independent
// expansion model (S-box derived from the GF(2^8) inverse) and handshake corner cases.

module tb_key_schedule_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         word_ready;
  logic [2:0]   start_v;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic [2:0]   busy_v, valid_v, done_v;
  logic [31:0]  word_v [3];
  logic [5:0]   idx_v  [3];
  logic [7:0]   rcon_v [3];

  key_schedule_gen #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst(rst), .start(start_v[0]), .key_in(key128), .busy(busy_v[0]),
    .word_valid(valid_v[0]), .word_ready(word_ready), .word_out(word_v[0]),
    .word_index(idx_v[0]), .rcon_out(rcon_v[0]), .done(done_v[0]));
  key_schedule_gen #(.KEY_BITS(192)) u_dut192 (
    .clk(clk), .rst(rst), .start(start_v[1]), .key_in(key192), .busy(busy_v[1]),
    .word_valid(valid_v[1]), .word_ready(word_ready), .word_out(word_v[1]),
    .word_index(idx_v[1]), .rcon_out(rcon_v[1]), .done(done_v[1]));
  key_schedule_gen #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst(rst), .start(start_v[2]), .key_in(key256), .busy(busy_v[2]),
    .word_valid(valid_v[2]), .word_ready(word_ready), .word_out(word_v[2]),
    .word_index(idx_v[2]), .rcon_out(rcon_v[2]), .done(done_v[2]));

  // Selected-DUT view used by the stream task.
  logic [1:0]  cur;
  logic        m_valid, m_busy, m_done;
  logic [31:0] m_word;
  logic [5:0]  m_index;
  logic [7:0]  m_rcon;

  always_comb begin
    case (cur)
      2'd1: begin
        m_valid = valid_v[1]; m_busy = busy_v[1]; m_done = done_v[1];
        m_word = word_v[1]; m_index = idx_v[1]; m_rcon = rcon_v[1];
      end
      2'd2: begin
        m_valid = valid_v[2]; m_busy = busy_v[2]; m_done = done_v[2];
        m_word = word_v[2]; m_index = idx_v[2]; m_rcon = rcon_v[2];
      end
      default: begin
        m_valid = valid_v[0]; m_busy = busy_v[0]; m_done = done_v[0];
        m_word = word_v[0]; m_index = idx_v[0]; m_rcon = rcon_v[0];
      end
    endcase
  end

  typedef struct {
    logic [1:0]  sel;
    int          idx;
    logic [31:0] word;
    logic [7:0]  rcon;
  } vec_t;

  vec_t        tbl [14];
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  sbox_m [256];
  logic [31:0] exp_w [64];
  logic [7:0]  exp_r [64];
  logic [31:0] cap_w [64];
  logic [7:0]  cap_r [64];

  localparam logic [255:0] K128 = 256'(128'h2b7e151628aed2a6abf7158809cf4f3c);
  localparam logic [255:0] K192 = 256'(192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b);
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KNEW = 256'(128'h000102030405060708090a0b0c0d0e0f);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word_m(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key, input int nk);
    logic [7:0]  rc;
    logic [31:0] t;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      exp_r[i] = 8'h00;
      if (i < nk) begin
        exp_w[i] = key[32*(nk-i)-1 -: 32];
      end else begin
        t = exp_w[i-1];
        if (i % nk == 0) begin
          t = sub_word_m({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          exp_r[i] = rc;
          rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end else if (nk == 8 && i % nk == 4) begin
          t = sub_word_m(t);
        end
        exp_w[i] = exp_w[i-nk] ^ t;
      end
    end
  endtask

  task automatic check_table(input logic [1:0] s);
    for (int k = 0; k < 14; k++) begin
      if (tbl[k].sel == s) begin
        chk($sformatf("fips%0d_w[%0d]", s, tbl[k].idx), cap_w[tbl[k].idx], tbl[k].word);
        chk($sformatf("fips%0d_rcon[%0d]", s, tbl[k].idx), 32'(cap_r[tbl[k].idx]), 32'(tbl[k].rcon));
      end
    end
  endtask

  // mode 0: ready=1; 1: random ready with a 5-cycle stall at i=10;
  // 2: start pulses at i=20 and in the done cycle; 3: reset at i=30.
  task automatic run_stream(input logic [1:0] s, input logic [255:0] key, input int nk, input int mode);
    int          total, n, cycles, vcycles, stall;
    logic        held, start_pulsed;
    logic [31:0] hw;
    logic [5:0]  hi;
    logic [7:0]  hr;
    total = 4 * (nk + 7);
    model_expand(key, nk);
    cur = s;
    key128 = key[127:0];
    key192 = key[191:0];
    key256 = key;
    n = 0; cycles = 0; vcycles = 0; stall = 0; held = 1'b0; start_pulsed = 1'b0;
    hw = 32'h0; hi = 6'd0; hr = 8'h00;
    @(negedge clk);
    word_ready = 1'b1;
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v = 3'b000;
    chk("valid_after_start", 32'(m_valid), 32'd1);
    chk("busy_after_start", 32'(m_busy), 32'd1);
    while (n < total && cycles < 2000) begin
      start_v = 3'b000;
      if (held) begin
        chk($sformatf("stall_word[%0d]", hi), m_word, hw);
        chk("stall_index", 32'(m_index), 32'(hi));
        chk("stall_rcon", 32'(m_rcon), 32'(hr));
        held = 1'b0;
      end
      chk("no_early_done", 32'(m_done), 32'd0);
      if (mode == 3 && m_valid && m_index == 6'd30) begin
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(m_busy), 32'd0);
        chk("rst_word", m_word, 32'h0);
        chk("rst_index", 32'(m_index), 32'd0);
        chk("rst_rcon", 32'(m_rcon), 32'd0);
        chk("rst_done", 32'(m_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("no_done_after_rst", 32'(m_done), 32'd0);
          chk("idle_after_rst", 32'(m_valid), 32'd0);
        end
        return;
      end
      if (mode == 1) begin
        if (m_valid && m_index == 6'd10 && stall < 5) begin
          word_ready = 1'b0;
          stall++;
        end else begin
          word_ready = ($urandom_range(0, 2) != 0);
        end
      end
      if (mode == 2 && m_valid && m_index == 6'd20 && !start_pulsed) begin
        start_v[s] = 1'b1;
        start_pulsed = 1'b1;
      end
      if (m_valid) vcycles++;
      if (m_valid && word_ready) begin
        chk($sformatf("index[%0d]", n), 32'(m_index), 32'(n));
        chk($sformatf("word%0d[%0d]", s, n), m_word, exp_w[n]);
        chk($sformatf("rcon%0d[%0d]", s, n), 32'(m_rcon), 32'(exp_r[n]));
        cap_w[n] = m_word;
        cap_r[n] = m_rcon;
        n++;
      end else if (m_valid) begin
        held = 1'b1;
        hw = m_word; hi = m_index; hr = m_rcon;
      end
      @(negedge clk);
      cycles++;
    end
    start_v = 3'b000;
    if (n < total) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: got %0d words, expected %0d", n, total);
    end
    word_ready = 1'b1;
    chk("done_pulse", 32'(m_done), 32'd1);
    chk("valid_low_at_done", 32'(m_valid), 32'd0);
    chk("busy_low_at_done", 32'(m_busy), 32'd0);
    if (mode == 0) begin
      chk("valid_cycles", 32'(vcycles), 32'(total));
      chk("stream_cycles", 32'(cycles), 32'(total));
    end
    if (mode == 2) start_v[s] = 1'b1;
    @(negedge clk);
    start_v = 3'b000;
    chk("done_one_cycle", 32'(m_done), 32'd0);
    chk("valid_idle", 32'(m_valid), 32'd0);
    chk("busy_idle", 32'(m_busy), 32'd0);
    if (mode == 2) begin
      @(negedge clk);
      chk("no_restart_valid", 32'(m_valid), 32'd0);
      chk("no_restart_busy", 32'(m_busy), 32'd0);
    end
  endtask

  initial begin
    tbl[0]  = '{2'd0,  0, 32'h2b7e1516, 8'h00};
    tbl[1]  = '{2'd0,  4, 32'ha0fafe17, 8'h01};
    tbl[2]  = '{2'd0,  5, 32'h88542cb1, 8'h00};
    tbl[3]  = '{2'd0,  8, 32'hf2c295f2, 8'h02};
    tbl[4]  = '{2'd0, 40, 32'hd014f9a8, 8'h36};
    tbl[5]  = '{2'd0, 43, 32'hb6630ca6, 8'h00};
    tbl[6]  = '{2'd1,  5, 32'h522c6b7b, 8'h00};
    tbl[7]  = '{2'd1,  6, 32'hfe0c91f7, 8'h01};
    tbl[8]  = '{2'd1, 48, 32'he98ba06f, 8'h80};
    tbl[9]  = '{2'd1, 51, 32'h01002202, 8'h00};
    tbl[10] = '{2'd2,  8, 32'h9ba35411, 8'h01};
    tbl[11] = '{2'd2, 12, 32'ha8b09c1a, 8'h00};
    tbl[12] = '{2'd2, 56, 32'hfe4890d1, 8'h40};
    tbl[13] = '{2'd2, 59, 32'h706c631e, 8'h00};

    build_sbox();
    rst = 1'b1; start_v = 3'b000; word_ready = 1'b0; cur = 2'd0;
    key128 = '0; key192 = '0; key256 = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      cur = 2'(d);
      #1;
      chk($sformatf("reset%0d_valid", d), 32'(m_valid), 32'd0);
      chk($sformatf("reset%0d_busy", d), 32'(m_busy), 32'd0);
      chk($sformatf("reset%0d_done", d), 32'(m_done), 32'd0);
      chk($sformatf("reset%0d_word", d), m_word, 32'h0);
      chk($sformatf("reset%0d_index", d), 32'(m_index), 32'd0);
      chk($sformatf("reset%0d_rcon", d), 32'(m_rcon), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    run_stream(2'd0, K128, 4, 0); check_table(2'd0);
    run_stream(2'd1, K192, 6, 0); check_table(2'd1);
    run_stream(2'd2, K256, 8, 0); check_table(2'd2);
    run_stream(2'd0, K128, 4, 1); check_table(2'd0);
    run_stream(2'd0, K128, 4, 2);
    run_stream(2'd0, K128, 4, 0); check_table(2'd0);
    run_stream(2'd0, K128, 4, 3);
    run_stream(2'd0, KNEW, 4, 0);
    chk("newkey_w0", cap_w[0], 32'h00010203);
    chk("newkey_rcon4", 32'(cap_r[4]), 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
